// File: rtl/matrix_slot_allocator.sv
// Matrix RAM slot allocator: NUM_SLOTS fixed slots of SLOT_WORDS words, age-based eviction
// on allocation and lookup of stored matrices by dimension.
//
// state         | meaning
// IDLE          | waiting for a pending alloc (has priority) or query
// ALLOC_SCAN    | walking slots, gathering free / same-dim / oldest candidates
// ALLOC_GRANT   | alloc_ack, chosen slot cleared to invalid
// WAIT_COMMIT   | granted slot being filled; commit or abort returns to IDLE
// QRY_SCAN      | walking slots, counting dimension matches
// QRY_DONE      | qry_ack with hit/base
module matrix_slot_allocator #(
    parameter int NUM_SLOTS   = 8,
    parameter int SLOT_WORDS  = 25,
    parameter int MAX_PER_DIM = 2,
    parameter int ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_alloc_req,
    input  logic [2:0]        i_alloc_m,
    input  logic [2:0]        i_alloc_n,
    input  logic              i_commit,
    input  logic              i_abort,
    output logic              o_alloc_ack,
    output logic              o_alloc_err,
    output logic              o_alloc_evict,
    output logic [2:0]        o_alloc_slot,
    output logic [ADDR_W-1:0] o_alloc_base,
    input  logic              i_qry_req,
    input  logic [2:0]        i_qry_m,
    input  logic [2:0]        i_qry_n,
    input  logic              i_qry_idx,
    output logic              o_qry_ack,
    output logic              o_qry_hit,
    output logic [ADDR_W-1:0] o_qry_base,
    output logic [3:0]        o_valid_count,
    output logic              o_busy
);

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_ALLOC_SCAN  = 3'd1;
    localparam logic [2:0] S_ALLOC_GRANT = 3'd2;
    localparam logic [2:0] S_WAIT_COMMIT = 3'd3;
    localparam logic [2:0] S_QRY_SCAN    = 3'd4;
    localparam logic [2:0] S_QRY_DONE    = 3'd5;

    localparam logic [2:0] LAST_SLOT = 3'(NUM_SLOTS - 1);
    localparam logic [3:0] MAX_CNT   = 4'(MAX_PER_DIM);

    logic [2:0]           r_state;
    logic [2:0]           r_scan;

    logic                 r_alloc_pend;
    logic [2:0]           r_am;
    logic [2:0]           r_an;
    logic                 r_qry_pend;
    logic [2:0]           r_qm;
    logic [2:0]           r_qn;
    logic                 r_qidx;

    logic [NUM_SLOTS-1:0] r_valid;
    logic [2:0]           r_m   [NUM_SLOTS];
    logic [2:0]           r_n   [NUM_SLOTS];
    logic [7:0]           r_age [NUM_SLOTS];

    logic                 r_free_found;
    logic [2:0]           r_free_idx;
    logic [3:0]           r_same_cnt;
    logic                 r_same_found;
    logic [2:0]           r_same_idx;
    logic [7:0]           r_same_age;
    logic                 r_old_found;
    logic [2:0]           r_old_idx;
    logic [7:0]           r_old_age;

    logic [3:0]           r_q_cnt;
    logic                 r_q_found;
    logic [2:0]           r_q_idx;

    logic [2:0]           r_pend_slot;
    logic [3:0]           r_valid_count;

    logic [2:0]           r_alloc_slot;
    logic [ADDR_W-1:0]    r_alloc_base;
    logic                 r_qry_hit;
    logic [ADDR_W-1:0]    r_qry_base;

    logic                 w_cur_valid;
    logic [7:0]           w_cur_age;
    logic                 w_cur_same_a;
    logic                 w_cur_same_q;
    logic                 w_dims_bad;
    logic                 w_g_evict;
    logic [2:0]           w_g_slot;
    logic [ADDR_W-1:0]    w_g_base;
    logic [ADDR_W-1:0]    w_q_base;
    logic                 w_alloc_ack;
    logic                 w_qry_ack;

    function automatic logic [ADDR_W-1:0] base_of(input logic [2:0] slot);
        logic [ADDR_W-1:0] ext;
        ext = ADDR_W'(slot);
        return ext * ADDR_W'(SLOT_WORDS);
    endfunction

    assign w_cur_valid  = r_valid[r_scan];
    assign w_cur_age    = r_age[r_scan];
    assign w_cur_same_a = w_cur_valid && (r_m[r_scan] == r_am) && (r_n[r_scan] == r_an);
    assign w_cur_same_q = w_cur_valid && (r_m[r_scan] == r_qm) && (r_n[r_scan] == r_qn);

    assign w_dims_bad = (r_am == 3'd0) || (r_am > 3'd5) || (r_an == 3'd0) || (r_an > 3'd5);

    always_comb begin
        w_g_evict = 1'b0;
        w_g_slot  = 3'd0;
        if (!w_dims_bad) begin
            if (r_same_cnt >= MAX_CNT) begin
                w_g_slot  = r_same_idx;
                w_g_evict = 1'b1;
            end else if (r_free_found) begin
                w_g_slot  = r_free_idx;
            end else begin
                w_g_slot  = r_old_idx;
                w_g_evict = 1'b1;
            end
        end
    end

    assign w_g_base = base_of(w_g_slot);
    assign w_q_base = r_q_found ? base_of(r_q_idx) : '0;

    assign w_alloc_ack = (r_state == S_ALLOC_GRANT);
    assign w_qry_ack   = (r_state == S_QRY_DONE);

    assign o_alloc_ack   = w_alloc_ack;
    assign o_alloc_err   = w_alloc_ack && w_dims_bad;
    assign o_alloc_evict = w_alloc_ack && w_g_evict;
    assign o_alloc_slot  = w_alloc_ack ? w_g_slot : r_alloc_slot;
    assign o_alloc_base  = w_alloc_ack ? w_g_base : r_alloc_base;
    assign o_qry_ack     = w_qry_ack;
    assign o_qry_hit     = w_qry_ack ? r_q_found : r_qry_hit;
    assign o_qry_base    = w_qry_ack ? w_q_base : r_qry_base;
    assign o_valid_count = r_valid_count;
    assign o_busy        = (r_state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_scan        <= 3'd0;
            r_alloc_pend  <= 1'b0;
            r_am          <= 3'd0;
            r_an          <= 3'd0;
            r_qry_pend    <= 1'b0;
            r_qm          <= 3'd0;
            r_qn          <= 3'd0;
            r_qidx        <= 1'b0;
            r_valid       <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_m[i]   <= 3'd0;
                r_n[i]   <= 3'd0;
                r_age[i] <= 8'd0;
            end
            r_free_found  <= 1'b0;
            r_free_idx    <= 3'd0;
            r_same_cnt    <= 4'd0;
            r_same_found  <= 1'b0;
            r_same_idx    <= 3'd0;
            r_same_age    <= 8'd0;
            r_old_found   <= 1'b0;
            r_old_idx     <= 3'd0;
            r_old_age     <= 8'd0;
            r_q_cnt       <= 4'd0;
            r_q_found     <= 1'b0;
            r_q_idx       <= 3'd0;
            r_pend_slot   <= 3'd0;
            r_valid_count <= 4'd0;
            r_alloc_slot  <= 3'd0;
            r_alloc_base  <= '0;
            r_qry_hit     <= 1'b0;
            r_qry_base    <= '0;
        end else begin
            // Sticky one-deep request capture; clears below take precedence
            if (i_alloc_req && !r_alloc_pend) begin
                r_alloc_pend <= 1'b1;
                r_am         <= i_alloc_m;
                r_an         <= i_alloc_n;
            end
            if (i_qry_req && !r_qry_pend) begin
                r_qry_pend <= 1'b1;
                r_qm       <= i_qry_m;
                r_qn       <= i_qry_n;
                r_qidx     <= i_qry_idx;
            end

            case (r_state)
                S_IDLE: begin
                    r_scan <= 3'd0;
                    if (r_alloc_pend) begin
                        r_free_found <= 1'b0;
                        r_free_idx   <= 3'd0;
                        r_same_cnt   <= 4'd0;
                        r_same_found <= 1'b0;
                        r_same_idx   <= 3'd0;
                        r_same_age   <= 8'd0;
                        r_old_found  <= 1'b0;
                        r_old_idx    <= 3'd0;
                        r_old_age    <= 8'd0;
                        r_state      <= S_ALLOC_SCAN;
                    end else if (r_qry_pend) begin
                        r_q_cnt   <= 4'd0;
                        r_q_found <= 1'b0;
                        r_q_idx   <= 3'd0;
                        r_state   <= S_QRY_SCAN;
                    end
                end

                S_ALLOC_SCAN: begin
                    if (!w_cur_valid && !r_free_found) begin
                        r_free_found <= 1'b1;
                        r_free_idx   <= r_scan;
                    end
                    // Strict '>' keeps the lowest index on age ties
                    if (w_cur_same_a) begin
                        r_same_cnt <= r_same_cnt + 4'd1;
                        if (!r_same_found || (w_cur_age > r_same_age)) begin
                            r_same_found <= 1'b1;
                            r_same_idx   <= r_scan;
                            r_same_age   <= w_cur_age;
                        end
                    end
                    if (w_cur_valid && (!r_old_found || (w_cur_age > r_old_age))) begin
                        r_old_found <= 1'b1;
                        r_old_idx   <= r_scan;
                        r_old_age   <= w_cur_age;
                    end
                    if (r_scan == LAST_SLOT) begin
                        r_state <= S_ALLOC_GRANT;
                    end else begin
                        r_scan <= r_scan + 3'd1;
                    end
                end

                S_ALLOC_GRANT: begin
                    r_alloc_slot <= w_g_slot;
                    r_alloc_base <= w_g_base;
                    if (w_dims_bad) begin
                        r_alloc_pend <= 1'b0;
                        r_state      <= S_IDLE;
                    end else begin
                        r_valid[w_g_slot] <= 1'b0;
                        r_pend_slot       <= w_g_slot;
                        if (w_g_evict) begin
                            r_valid_count <= r_valid_count - 4'd1;
                        end
                        r_state <= S_WAIT_COMMIT;
                    end
                end

                S_WAIT_COMMIT: begin
                    if (i_commit) begin
                        for (int i = 0; i < NUM_SLOTS; i++) begin
                            if (r_valid[i] && (r_age[i] != 8'hFF)) begin
                                r_age[i] <= r_age[i] + 8'd1;
                            end
                        end
                        r_valid[r_pend_slot] <= 1'b1;
                        r_m[r_pend_slot]     <= r_am;
                        r_n[r_pend_slot]     <= r_an;
                        r_age[r_pend_slot]   <= 8'd0;
                        r_valid_count        <= r_valid_count + 4'd1;
                        r_alloc_pend         <= 1'b0;
                        r_state              <= S_IDLE;
                    end else if (i_abort) begin
                        r_alloc_pend <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end

                S_QRY_SCAN: begin
                    if (w_cur_same_q) begin
                        if (!r_q_found && (r_q_cnt == {3'b000, r_qidx})) begin
                            r_q_found <= 1'b1;
                            r_q_idx   <= r_scan;
                        end
                        r_q_cnt <= r_q_cnt + 4'd1;
                    end
                    if (r_scan == LAST_SLOT) begin
                        r_state <= S_QRY_DONE;
                    end else begin
                        r_scan <= r_scan + 3'd1;
                    end
                end

                S_QRY_DONE: begin
                    r_qry_hit  <= r_q_found;
                    r_qry_base <= w_q_base;
                    r_qry_pend <= 1'b0;
                    r_state    <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
